// File: rtl/fft_out_pkg.sv
// Shared types, default geometry and derived-size helpers for the FFT output controller.
package fft_out_pkg;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} fft_out_state_t;

    localparam int unsigned SIZE    = 16;
    localparam int unsigned SAMPLES = 2048;
    localparam int unsigned LINE_W  = 512;

    function automatic int unsigned lines_f(input int unsigned samples,
                                            input int unsigned size,
                                            input int unsigned line_w);
        return (samples * size) / line_w;
    endfunction

    function automatic int unsigned spl_f(input int unsigned line_w,
                                          input int unsigned size);
        return line_w / size;
    endfunction

endpackage

// File: rtl/fft_line_stage.sv
// Single output register for host lines; holds data and line number while the sink stalls.
module fft_line_stage #(
    parameter int unsigned DW = 512,
    parameter int unsigned LW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          m_ready,
    input  logic [DW-1:0] in_data,
    input  logic [LW-1:0] in_line,
    output logic          load_c,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    output logic [LW-1:0] m_line
);

    // Refill whenever the register is empty or being emptied this cycle.
    assign load_c = en & (~m_valid | m_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_line  <= '0;
        end else if (load_c) begin
            m_valid <= 1'b1;
            m_data  <= in_data;
            m_line  <= in_line;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fft_output_ctrl.sv
// Frame sequencer: fills the sample buffer from the FFT core, then drains it as host lines.
module fft_output_ctrl #(
    parameter int unsigned SIZE    = fft_out_pkg::SIZE,
    parameter int unsigned SAMPLES = fft_out_pkg::SAMPLES,
    parameter int unsigned LINE_W  = fft_out_pkg::LINE_W,
    localparam int unsigned SW     = $clog2(SAMPLES),
    localparam int unsigned LW     = $clog2(SAMPLES * SIZE / LINE_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [SIZE-1:0]   s_data,
    output logic              buf_wr_en,
    output logic [SW-1:0]     buf_wr_index,
    output logic [SIZE-1:0]   buf_wr_data,
    output logic [LW-1:0]     buf_rd_index,
    input  logic [LINE_W-1:0] buf_rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [LINE_W-1:0] m_data,
    output logic [LW-1:0]     m_line,
    output logic              err_ovf
);

    import fft_out_pkg::*;

    localparam int unsigned LINES = lines_f(SAMPLES, SIZE, LINE_W);
    localparam int unsigned SPL   = spl_f(LINE_W, SIZE);

    localparam logic [SW:0] WCNT_LAST = (SW+1)'(SAMPLES - 1);
    localparam logic [LW:0] RCNT_END  = (LW+1)'(LINES);
    localparam logic [LW-1:0] LINE_LAST = LW'(LINES - 1);

    if ((SPL * SIZE != LINE_W) || (LINES * LINE_W != SAMPLES * SIZE)) begin : g_bad_geometry
        $error("fft_output_ctrl: SAMPLES*SIZE must be a multiple of LINE_W and LINE_W of SIZE");
    end

    fft_out_state_t state;
    logic [SW:0]    wcnt;
    logic [LW:0]    rcnt;
    logic           fire;
    logic           line_en;
    logic           load;
    logic           accept_last;

    // Buffer write path is a straight pass-through of the accepted sample.
    assign fire         = s_valid & s_ready;
    assign buf_wr_en    = fire;
    assign buf_wr_index = wcnt[SW-1:0];
    assign buf_wr_data  = s_data;
    assign buf_rd_index = rcnt[LW-1:0];

    assign line_en     = (state == DRAIN) && (rcnt < RCNT_END);
    assign accept_last = m_valid & m_ready & (m_line == LINE_LAST);

    fft_line_stage #(
        .DW (LINE_W),
        .LW (LW)
    ) u_line_stage (
        .clk     (clk),
        .rst     (rst),
        .en      (line_en),
        .m_ready (m_ready),
        .in_data (buf_rd_data),
        .in_line (rcnt[LW-1:0]),
        .load_c  (load),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_line  (m_line)
    );

    // FSM, counters and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            wcnt    <= '0;
            rcnt    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            s_ready <= 1'b0;
            err_ovf <= 1'b0;
        end else begin
            if (s_valid && (state != FILL)) begin
                err_ovf <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= FILL;
                        wcnt    <= '0;
                        err_ovf <= 1'b0;
                        busy    <= 1'b1;
                        s_ready <= 1'b1;
                    end
                end
                FILL: begin
                    if (fire) begin
                        wcnt <= wcnt + (SW+1)'(1);
                        if (wcnt == WCNT_LAST) begin
                            state   <= DRAIN;
                            rcnt    <= '0;
                            s_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (load) begin
                        rcnt <= rcnt + (LW+1)'(1);
                    end
                    if (accept_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_output_ctrl.sv
// Self-checking bench for fft_output_ctrl: control vector table plus scoreboarded full frames.
module tb_fft_output_ctrl;

    localparam int unsigned SIZE    = 16;
    localparam int unsigned SAMPLES = 2048;
    localparam int unsigned LINE_W  = 512;
    localparam int unsigned LINES   = 64;
    localparam int unsigned SPL     = 32;
    localparam int unsigned SW      = 11;
    localparam int unsigned LW      = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              busy, done;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [SIZE-1:0]   s_data = '0;
    logic              buf_wr_en;
    logic [SW-1:0]     buf_wr_index;
    logic [SIZE-1:0]   buf_wr_data;
    logic [LW-1:0]     buf_rd_index;
    logic [LINE_W-1:0] buf_rd_data;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [LINE_W-1:0] m_data;
    logic [LW-1:0]     m_line;
    logic              err_ovf;

    fft_output_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .buf_wr_en(buf_wr_en), .buf_wr_index(buf_wr_index), .buf_wr_data(buf_wr_data),
        .buf_rd_index(buf_rd_index), .buf_rd_data(buf_rd_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_line(m_line),
        .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    // External sample buffer: sample j of a line sits at bits [j*SIZE +: SIZE].
    logic [SIZE-1:0] mem [SAMPLES];
    always @(posedge clk) if (buf_wr_en) mem[buf_wr_index] <= buf_wr_data;
    always_comb begin
        buf_rd_data = '0;
        for (int j = 0; j < SPL; j++)
            buf_rd_data[j*SIZE +: SIZE] = mem[int'(buf_rd_index) * SPL + j];
    end

    typedef struct { int idx; int data; } wr_t;
    typedef struct { int line; logic [LINE_W-1:0] data; } line_t;
    typedef struct {
        bit rst, start, sv; logic [SIZE-1:0] d;
        bit e_wr; int e_idx; bit e_busy, e_rdy, e_err;
    } vec_t;

    wr_t   wr_q[$];
    line_t line_q[$];
    logic [SIZE-1:0] exp_samp [SAMPLES];

    int n_vec = 0, n_fail = 0;
    int frame_id = 0;
    int cyc = 0, last_wr_cyc = 0, first_v_cyc = 0, last_acc_cyc = 0;
    int wr_cnt = 0, acc_cnt = 0, done_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_line(input string nm, input logic [LINE_W-1:0] act,
                            input logic [LINE_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] line_of(input int k);
        logic [LINE_W-1:0] r;
        for (int j = 0; j < SPL; j++) r[j*SIZE +: SIZE] = exp_samp[k*SPL + j];
        return r;
    endfunction

    // Monitor: samples 2 time units before each rising edge.
    always begin : monitor
        int last_fid;
        bit seen_first, prev_stall;
        logic [LINE_W-1:0] prev_data;
        int prev_line;
        wr_t w;
        line_t l;
        @(negedge clk);
        #3;
        cyc++;
        if (frame_id != last_fid) begin
            last_fid = frame_id; wr_cnt = 0; acc_cnt = 0; seen_first = 0;
        end
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (buf_wr_en) begin
                chk("wr_needs_valid", int'(s_valid), 1);
                if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    w = wr_q.pop_front();
                    chk("wr_index", int'(buf_wr_index), w.idx);
                    chk("wr_data", int'(buf_wr_data), w.data);
                end
                wr_cnt++; last_wr_cyc = cyc;
            end
            if (m_valid && !seen_first) begin
                seen_first = 1; first_v_cyc = cyc;
                chk("first_line_latency", cyc - last_wr_cyc, 2);
                chk("writes_before_drain", wr_cnt, SAMPLES);
            end
            if (prev_stall) begin
                chk("stall_valid", int'(m_valid), 1);
                chk("stall_line", int'(m_line), prev_line);
                chk_line("stall_data", m_data, prev_data);
            end
            if (m_valid && m_ready) begin
                if (line_q.size() == 0) chk("line_unexpected", int'(m_line), -1);
                else begin
                    l = line_q.pop_front();
                    chk("line_num", int'(m_line), l.line);
                    chk_line("line_data", m_data, l.data);
                end
                acc_cnt++; last_acc_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                chk("done_latency", cyc - last_acc_cyc, 1);
            end
            prev_stall = m_valid & ~m_ready;
            prev_data  = m_data;
            prev_line  = int'(m_line);
        end
    end

    // abort: 0 none, 1 reset during fill, 2 reset after line 10 of drain.
    task automatic run_frame(input int pct, input int rmode, input int abort);
        int d0, t;
        d0 = done_cnt;
        @(negedge clk);
        frame_id++; start = 1'b1; m_ready = (rmode == 0);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < SAMPLES; i++) begin
            if (abort == 1 && i == 300) begin
                s_valid = 1'b0; rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("fill_abort_busy", int'(busy), 0);
                chk("fill_abort_ready", int'(s_ready), 0);
                chk("fill_abort_writes", wr_q.size(), 0);
                repeat (3) @(negedge clk);
                chk("fill_abort_no_done", done_cnt - d0, 0);
                return;
            end
            while ($urandom_range(99) >= pct) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            s_valid = 1'b1;
            s_data  = (pct == 100) ? SIZE'(i) : SIZE'($urandom);
            start   = (rmode == 1 && i == 100);
            exp_samp[i] = s_data;
            wr_q.push_back('{i, int'(s_data)});
            @(negedge clk);
            start = 1'b0;
        end
        s_valid = 1'b0;
        for (int k = 0; k < LINES; k++) line_q.push_back('{k, line_of(k)});
        t = 0;
        while (done_cnt == d0 && t < 3000) begin
            if (rmode == 1) m_ready = (t % 4 == 0) || (t % 4 == 3);
            start = (rmode == 1 && t == 7);
            if (abort == 2 && acc_cnt > 10) begin
                start = 1'b0; rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("drain_abort_valid", int'(m_valid), 0);
                chk("drain_abort_busy", int'(busy), 0);
                line_q.delete();
                repeat (5) @(negedge clk);
                chk("drain_abort_no_done", done_cnt - d0, 0);
                chk("drain_abort_still_idle", int'(m_valid), 0);
                return;
            end
            @(negedge clk);
            t++;
        end
        start = 1'b0;
        chk("busy_after_done", int'(busy), 0);
        @(negedge clk);
        chk("done_pulses", done_cnt - d0, 1);
        chk("lines_left", line_q.size(), 0);
        chk("lines_accepted", acc_cnt, LINES);
        chk("samples_written", wr_cnt, SAMPLES);
        chk("err_after_frame", int'(err_ovf), 0);
        if (rmode == 0) chk("drain_cycles", last_acc_cyc - first_v_cyc, LINES - 1);
    endtask

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        vec_t vt [8];
        vt[0] = '{1, 0, 0, 16'h0000, 0, 0, 0, 0, 0};
        vt[1] = '{0, 0, 1, 16'h1111, 0, 0, 0, 0, 1};
        vt[2] = '{0, 0, 0, 16'h0000, 0, 0, 0, 0, 1};
        vt[3] = '{0, 1, 0, 16'h0000, 0, 0, 1, 1, 0};
        vt[4] = '{0, 0, 1, 16'hA5A5, 1, 0, 1, 1, 0};
        vt[5] = '{0, 1, 0, 16'h0000, 0, 0, 1, 1, 0};
        vt[6] = '{0, 0, 1, 16'h5A5A, 1, 1, 1, 1, 0};
        vt[7] = '{1, 0, 0, 16'h0000, 0, 0, 0, 0, 0};

        repeat (2) @(negedge clk);
        for (int r = 0; r < 8; r++) begin
            @(negedge clk);
            rst = vt[r].rst; start = vt[r].start; s_valid = vt[r].sv; s_data = vt[r].d;
            if (vt[r].e_wr) wr_q.push_back('{vt[r].e_idx, int'(vt[r].d)});
            #1;
            chk("vec_wr_en", int'(buf_wr_en), int'(vt[r].e_wr));
            @(posedge clk);
            #1;
            chk("vec_busy", int'(busy), int'(vt[r].e_busy));
            chk("vec_s_ready", int'(s_ready), int'(vt[r].e_rdy));
            chk("vec_err_ovf", int'(err_ovf), int'(vt[r].e_err));
            chk("vec_done", int'(done), 0);
            chk("vec_m_valid", int'(m_valid), 0);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0; s_valid = 1'b0;
        chk("vec_writes_drained", wr_q.size(), 0);

        run_frame(100, 0, 1);
        run_frame(100, 0, 0);
        run_frame(50, 0, 0);
        run_frame(100, 1, 0);
        run_frame(100, 0, 2);
        run_frame(70, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
